// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the SimpleRISC controller.
//                Holds the FSM state enum, instruction-class enum, opcode /
//                ALUop / vsel encodings, the registered control bundle and
//                an instruction classifier used by the sequencer.
//  Revision    : 1.0  - initial release
// ============================================================================
package cpu_pkg;

    // Sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        GET_A     = 3'd2,
        GET_B     = 3'd3,
        EXEC      = 3'd4,
        WRITE_REG = 3'd5,
        WRITE_IMM = 3'd6
    } state_t;

    // Instruction classes the sequencer distinguishes
    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_MVN     = 3'd3,
        CLS_ADD     = 3'd4,
        CLS_CMP     = 3'd5,
        CLS_AND     = 3'd6
    } instr_cls_t;

    // Opcode field values
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field values within the MOV opcode
    localparam logic [1:0] MOV_OP_REG = 2'b00;
    localparam logic [1:0] MOV_OP_IMM = 2'b10;

    // ALUop encodings (also the op field within the ALU opcode)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Writeback mux select encodings
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Registered control bundle driven toward the datapath
    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       loadc;
        logic       loads;
    } ctrl_t;

    // Idle bundle: everything low except the ready flag
    localparam ctrl_t CTRL_IDLE = '{
        w:        1'b1,
        readnum:  3'd0,
        writenum: 3'd0,
        write:    1'b0,
        vsel:     VSEL_C,
        loada:    1'b0,
        loadb:    1'b0,
        asel:     1'b0,
        loadc:    1'b0,
        loads:    1'b0
    };

    // Map opcode/op to an instruction class; unknown encodings are NOPs
    function automatic instr_cls_t classify(input logic [2:0] opcode,
                                            input logic [1:0] op);
        instr_cls_t cls;
        cls = CLS_NOP;
        if (opcode == OPC_MOV) begin
            if (op == MOV_OP_IMM) begin
                cls = CLS_MOV_IMM;
            end else if (op == MOV_OP_REG) begin
                cls = CLS_MOV_REG;
            end
        end else if (opcode == OPC_ALU) begin
            case (op)
                ALU_ADD: cls = CLS_ADD;
                ALU_SUB: cls = CLS_CMP;
                ALU_AND: cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_instr_dec.sv
`default_nettype none
// ============================================================================
//  Module      : instr_dec
//  Description : Purely combinational instruction field splitter and
//                sign-extender for the 16-bit SimpleRISC instruction word.
//  Ports       : i_ir      - instruction register contents
//                o_opcode  - IR[15:13]      o_op  - IR[12:11]
//                o_rn      - IR[10:8]       o_rd  - IR[7:5]
//                o_sh      - IR[4:3]        o_rm  - IR[2:0]
//                o_sximm8  - IR[7:0] sign-extended to 16 bits
//                o_sximm5  - IR[4:0] sign-extended to 16 bits
//  Revision    : 1.0  - initial release
// ============================================================================
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_opcode,
    output logic [1:0]  o_op,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [1:0]  o_sh,
    output logic [2:0]  o_rm,
    output logic [15:0] o_sximm8,
    output logic [15:0] o_sximm5
);

    assign o_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];

    assign o_sximm8 = {{8{i_ir[7]}},  i_ir[7:0]};
    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : SimpleRISC control unit. Holds the instruction register and
//                runs a Moore FSM that sequences the datapath strobes for one
//                MOV/ALU instruction per start pulse. All strobes are
//                registered: the bundle for the state being entered is
//                computed from the next state and loaded on the same edge.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous active-high reset
//                s        - start executing the instruction in IR
//                load     - capture `in` into IR (honoured only in WAIT)
//                in       - instruction word
//                w        - idle in WAIT, ready for s
//                readnum / writenum / write / vsel - register file control
//                loada / loadb / asel / bsel / loadc / loads - datapath ctrl
//                shift / ALUop / sximm8 / sximm5 - decoded from IR
//  Revision    : 1.0  - initial release
// ============================================================================
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    logic [15:0] r_ir;
    state_t      r_state;
    state_t      w_next_state;
    ctrl_t       r_ctrl;
    ctrl_t       w_next_ctrl;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    instr_cls_t  w_cls;

    instr_dec u_instr_dec (
        .i_ir     (r_ir),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm8 (sximm8),
        .o_sximm5 (sximm5)
    );

    assign w_cls = classify(w_opcode, w_op);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT: begin
                if (s) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                case (w_cls)
                    CLS_MOV_IMM:                      w_next_state = WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:             w_next_state = GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:        w_next_state = GET_A;
                    default:                          w_next_state = WAIT;
                endcase
            end
            GET_A:     w_next_state = GET_B;
            GET_B:     w_next_state = EXEC;
            EXEC: begin
                // CMP only updates status, so there is nothing to write back
                if (w_cls == CLS_CMP) begin
                    w_next_state = WAIT;
                end else begin
                    w_next_state = WRITE_REG;
                end
            end
            WRITE_REG: w_next_state = WAIT;
            WRITE_IMM: w_next_state = WAIT;
            default:   w_next_state = WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe bundle for the state about to be entered. IR cannot change
    // outside WAIT, and DECODE drives no IR-dependent strobes, so the
    // fields read here always belong to the instruction being executed.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_ctrl = '0;
        case (w_next_state)
            WAIT: begin
                w_next_ctrl.w = 1'b1;
            end
            GET_A: begin
                w_next_ctrl.readnum = w_rn;
                w_next_ctrl.loada   = 1'b1;
            end
            GET_B: begin
                w_next_ctrl.readnum = w_rm;
                w_next_ctrl.loadb   = 1'b1;
            end
            EXEC: begin
                // MOV reg and MVN ignore the A operand
                w_next_ctrl.asel = (w_cls == CLS_MOV_REG) || (w_cls == CLS_MVN);
                if (w_cls == CLS_CMP) begin
                    w_next_ctrl.loads = 1'b1;
                end else begin
                    w_next_ctrl.loadc = 1'b1;
                end
            end
            WRITE_REG: begin
                w_next_ctrl.writenum = w_rd;
                w_next_ctrl.vsel     = VSEL_C;
                w_next_ctrl.write    = 1'b1;
            end
            WRITE_IMM: begin
                w_next_ctrl.writenum = w_rn;
                w_next_ctrl.vsel     = VSEL_IMM8;
                w_next_ctrl.write    = 1'b1;
            end
            default: begin
                w_next_ctrl = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, IR and registered strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT;
            r_ir    <= 16'h0000;
            r_ctrl  <= CTRL_IDLE;
        end else begin
            if ((r_state == WAIT) && load) begin
                r_ir <= in;
            end
            r_state <= w_next_state;
            r_ctrl  <= w_next_ctrl;
        end
    end

    assign w        = r_ctrl.w;
    assign readnum  = r_ctrl.readnum;
    assign writenum = r_ctrl.writenum;
    assign write    = r_ctrl.write;
    assign vsel     = r_ctrl.vsel;
    assign loada    = r_ctrl.loada;
    assign loadb    = r_ctrl.loadb;
    assign asel     = r_ctrl.asel;
    assign loadc    = r_ctrl.loadc;
    assign loads    = r_ctrl.loads;

    // B operand always comes from the register file in this revision
    assign bsel     = 1'b0;

    assign shift    = w_sh;
    // MOV reg encodes op = 00, so the add it needs in EXEC comes straight
    // from the instruction field without any override.
    assign ALUop    = w_op;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_controller
//  Description : Self-checking bench for cpu_controller. A small behavioural
//                datapath is driven by the controller's strobes; per-cycle
//                expected strobe vectors are queued from the instruction word
//                and popped against the DUT every cycle.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .loadc    (loadc),
        .loads    (loads),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural datapath driven by the controller strobes
    // ------------------------------------------------------------------
    logic [15:0] R [8] = '{default: 16'h0000};
    logic [15:0] rA = 16'h0000;
    logic [15:0] rB = 16'h0000;
    logic [15:0] rC = 16'h0000;
    logic [2:0]  nvz = 3'b000;
    logic [15:0] b_sh, ain, bin, alu_out;
    logic        ovf;

    always_comb begin
        case (shift)
            2'b00:   b_sh = rB;
            2'b01:   b_sh = rB << 1;
            2'b10:   b_sh = rB >> 1;
            default: b_sh = {rB[15], rB[15:1]};
        endcase
        ain = asel ? 16'h0000 : rA;
        bin = bsel ? sximm5 : b_sh;
        case (ALUop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
        ovf = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
    end

    always @(posedge clk) begin
        if (write)  R[writenum] <= (vsel == 2'b10) ? sximm8 : rC;
        if (loada)  rA <= R[readnum];
        if (loadb)  rB <= R[readnum];
        if (loadc)  rC <= alu_out;
        if (loads)  nvz <= {alu_out[15], ovf, (alu_out == 16'h0000)};
    end

    // ------------------------------------------------------------------
    // Expected-vector helpers
    // ------------------------------------------------------------------
    function automatic logic [15:0] mkv(input logic ew, input logic [2:0] ern,
                                        input logic [2:0] ewn, input logic ewr,
                                        input logic [1:0] evs, input logic ela,
                                        input logic elb, input logic eas,
                                        input logic elc, input logic els);
        return {ew, ern, ewn, ewr, evs, ela, elb, eas, 1'b0, elc, els};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads};
    endfunction

    // Queue the strobe vector seen in each cycle after the edge that samples s,
    // ending with the return to WAIT; returns the expected latency.
    function automatic int push_expected(input logic [15:0] ir);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op;
        int lat;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
        exp_q.push_back(mkv(0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0));          // DECODE
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(mkv(0, 3'd0, rn, 1, 2'b10, 0, 0, 0, 0, 0));        // WRITE_IMM
            lat = 2;
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            exp_q.push_back(mkv(0, rm, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0));        // GET_B
            exp_q.push_back(mkv(0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 1, 1, 0));      // EXEC
            exp_q.push_back(mkv(0, 3'd0, rd, 1, 2'b00, 0, 0, 0, 0, 0));        // WRITE_REG
            lat = 4;
        end else if (opc == 3'b101) begin
            exp_q.push_back(mkv(0, rn, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0));        // GET_A
            exp_q.push_back(mkv(0, rm, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0));        // GET_B
            if (op == 2'b01) begin
                exp_q.push_back(mkv(0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 1));  // EXEC (CMP)
                lat = 4;
            end else begin
                exp_q.push_back(mkv(0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 1, 0));  // EXEC
                exp_q.push_back(mkv(0, 3'd0, rd, 1, 2'b00, 0, 0, 0, 0, 0));    // WRITE_REG
                lat = 5;
            end
        end else begin
            lat = 1;
        end
        exp_q.push_back(mkv(1, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0));          // WAIT
        return lat;
    endfunction

    // Load (or load together with s), launch, and compare every cycle.
    // glitch_at > 0 pulses load with 16'hE000 in that cycle after launch.
    task automatic run_instr(input logic [15:0] ir, input bit together,
                             input int glitch_at, input string tag);
        int lat, k, seen;
        logic [15:0] ev, ov;
        @(negedge clk);
        load = 1'b1;
        in   = ir;
        if (!together) begin
            @(negedge clk);
            load = 1'b0;
        end
        s   = 1'b1;
        lat = push_expected(ir);
        @(posedge clk);
        k = 0;
        seen = -1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            k++;
            s    = 1'b0;
            load = 1'b0;
            if (k == glitch_at) begin
                load = 1'b1;
                in   = 16'hE000;
            end
            ev = exp_q.pop_front();
            ov = obs_vec();
            n_checks++;
            if (ov !== ev) begin
                n_fail++;
                $display("FAIL %s strobes cycle %0d: got %h expected %h", tag, k, ov, ev);
            end
            if (seen < 0 && w === 1'b1) seen = k - 1;
        end
        load = 1'b0;
        n_checks++;
        if (seen !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, seen, lat);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [15:0] idle;
        idle = mkv(1, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0);
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        #1;
        n_checks++;
        if (obs_vec() !== idle) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), idle);
        end
        @(negedge clk); reset = 1'b0;
        // Launch ADD and abort it in GET_A
        @(negedge clk); load = 1'b1; in = 16'hA148;
        @(negedge clk); load = 1'b0; s = 1'b1;
        @(posedge clk);
        @(negedge clk); s = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (loada !== 1'b1 || readnum !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_pre_get_a: got loada=%b readnum=%0d expected loada=1 readnum=1", loada, readnum);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs_vec() !== idle) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs_vec(), idle);
        end
        n_checks++;
        if (sximm8 !== 16'h0000 || shift !== 2'b00 || ALUop !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ir: got sximm8=%h shift=%b ALUop=%b expected 0000/00/00", sximm8, shift, ALUop);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== idle) begin
                n_fail++;
                $display("FAIL reset_no_write cycle %0d: got %h expected %h", i, obs_vec(), idle);
            end
        end
        n_checks++;
        if (R[2] !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_r2: got %h expected 0000", R[2]);
        end
    endtask

    task automatic test_mov_imm();
        run_instr(16'hD007, 1'b0, 0, "mov_imm_r0");
        n_checks++;
        if (sximm8 !== 16'h0007 || R[0] !== 16'h0007) begin
            n_fail++;
            $display("FAIL mov_imm_r0 data: got sximm8=%h R0=%h expected 0007/0007", sximm8, R[0]);
        end
        run_instr(16'hD4FF, 1'b0, 0, "mov_imm_r4");
        n_checks++;
        if (sximm8 !== 16'hFFFF || R[4] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL mov_imm_r4 data: got sximm8=%h R4=%h expected FFFF/FFFF", sximm8, R[4]);
        end
        run_instr(16'hD102, 1'b0, 0, "mov_imm_r1");
        n_checks++;
        if (R[1] !== 16'h0002) begin
            n_fail++;
            $display("FAIL mov_imm_r1 data: got %h expected 0002", R[1]);
        end
    endtask

    task automatic test_add();
        run_instr(16'hA148, 1'b0, 0, "add");
        n_checks++;
        if (R[2] !== 16'h0010 || shift !== 2'b01 || ALUop !== 2'b00) begin
            n_fail++;
            $display("FAIL add data: got R2=%h shift=%b ALUop=%b expected 0010/01/00", R[2], shift, ALUop);
        end
    endtask

    task automatic test_cmp();
        run_instr(16'hA801, 1'b0, 0, "cmp_ne");
        n_checks++;
        if (nvz !== 3'b000 || ALUop !== 2'b01) begin
            n_fail++;
            $display("FAIL cmp_ne status: got nvz=%b ALUop=%b expected 000/01", nvz, ALUop);
        end
        run_instr(16'hA800, 1'b0, 0, "cmp_eq");
        n_checks++;
        if (nvz !== 3'b001) begin
            n_fail++;
            $display("FAIL cmp_eq status: got %b expected 001", nvz);
        end
    endtask

    task automatic test_mvn_mov();
        run_instr(16'hB860, 1'b0, 0, "mvn");
        n_checks++;
        if (R[3] !== 16'hFFF8) begin
            n_fail++;
            $display("FAIL mvn data: got %h expected FFF8", R[3]);
        end
        run_instr(16'hC0A0, 1'b0, 0, "mov_reg");
        n_checks++;
        if (R[5] !== 16'h0007) begin
            n_fail++;
            $display("FAIL mov_reg data: got %h expected 0007", R[5]);
        end
    endtask

    task automatic test_illegal();
        run_instr(16'hE000, 1'b0, 0, "illegal");
    endtask

    task automatic test_load_in_exec();
        // EXEC of MVN is the third cycle after launch
        run_instr(16'hB860, 1'b0, 3, "load_in_exec");
        n_checks++;
        if (sximm8 !== 16'h0060 || ALUop !== 2'b11) begin
            n_fail++;
            $display("FAIL load_in_exec ir: got sximm8=%h ALUop=%b expected 0060/11", sximm8, ALUop);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(16'hD60C, 1'b1, 0, "s_with_load");
        n_checks++;
        if (R[6] !== 16'h000C) begin
            n_fail++;
            $display("FAIL s_with_load data: got %h expected 000C", R[6]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_mvn_mov();
        test_illegal();
        test_load_in_exec();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
